divide: RTL and testbench
=========================

# divide

Sequential unsigned integer divider by repeated subtraction, the inverse of the repeated-addition multiplier in the same arithmetic unit. It accepts a dividend and divisor on a start/Ready handshake and returns quotient and remainder. Busy time is proportional to the quotient value. A divide-by-zero flag is raised when the divisor is zero. It shares the multiplier's two-state controller/datapath style and its Ready semantics, so both units are driven by the same sequencing logic.

## Interface
- WIDTH, 8, operand, quotient and remainder width in bits
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled only on the rising edge of clock
- start  in  1  request; accepted only when Ready=1
- dividend  in  WIDTH  unsigned, sampled on accept
- divisor  in  WIDTH  unsigned, sampled on accept
- Quotient  out  WIDTH  registered quotient
- Remainder  out  WIDTH  registered remainder
- Ready  out  1  high in idle state
- DivZero  out  1  registered; set when the accepted divisor was 0

## Operation
- States: S_Idle and S_Div. Reset state is S_Idle.
- Load = Ready & start. Sub = (state==S_Div) & (Remainder >= D), where D is the internal divisor register.
- S_Idle, Load, divisor≠0:
  - D<=divisor, Remainder<=dividend, Quotient<=0, DivZero<=0.
  - Next state S_Div.
- S_Idle, Load, divisor==0:
  - Quotient<='1 (all ones), Remainder<=dividend, DivZero<=1.
  - State stays S_Idle.
- S_Div, Sub:
  - Remainder<=Remainder-D, Quotient<=Quotient+1.
  - State stays S_Div.
- S_Div, !Sub: next state S_Idle; registers hold.
- start while Ready=0 is ignored. Operands are not re-sampled.
- Results and DivZero hold until the next accepted start or reset.
- Arithmetic rules:
  - All arithmetic is unsigned, WIDTH bits.
  - The subtraction never underflows, because it is guarded by the >= compare.
  - The quotient cannot overflow: the maximum is 2^WIDTH-1, reached when divisor=1.
- Reset values: Quotient=0, Remainder=0, D=0, DivZero=0, state S_Idle, Ready=1.

## Timing
- Accept edge: rising edge with Ready=1 and start=1.
- For divisor≠0, Ready is low for exactly q+1 cycles after the accept edge, where q = dividend/divisor.
- Quotient and Remainder are final on the edge where Ready returns high.
- For divisor==0, Ready stays high. Results and DivZero are valid the cycle after the accept edge.
- Intermediate Quotient/Remainder values are visible while Ready=0. They are defined as partial results only.
- Boundary cases:
  - dividend < divisor: 1 busy cycle; Q=0, R=dividend.
  - dividend == divisor: 2 busy cycles; Q=1, R=0.
  - dividend=0, divisor≠0: 1 busy cycle; Q=0, R=0.
- Reset asserted mid-operation:
  - Takes effect at the next edge: all registers take their reset values and the state returns to S_Idle.
  - Ready=1 in the following cycle. The operation in progress is discarded.
- Reset and start in the same cycle: reset wins.
- A new start on the same cycle that Ready rises is accepted, so back-to-back operations carry no dead cycle.

## Structure
- Shared arithmetic package holds:
  - state encodings S_Idle=1'b0 and S_Div=1'b1, common with the multiplier;
  - the default operand width constant.
- Two sub-modules:
  - divide_ctrl: state register, next-state logic, and the Ready/Load/Sub decode.
  - divide_dp: D/Remainder/Quotient/DivZero registers, the >= comparator, and the subtractor.
  - Interface between them: Load, Sub and Ge (Remainder>=D), plus the dz signal (divisor==0 at load).
- The top level divide instantiates only these two sub-modules.

## Test plan
- Reset, then 100/7 with start pulsed one cycle: Ready low 15 cycles, then Quotient=14, Remainder=2, DivZero=0.
- 255/1: Ready low 256 cycles, Quotient=255, Remainder=0. Then 5/9: 1 busy cycle, Q=0, R=5.
- 42/0: Ready never drops. Next cycle Quotient=8'hFF, Remainder=42, DivZero=1. Then 10/3: DivZero clears, Q=3, R=1.
- 200/10 with start held high throughout: mid-op start is ignored. Q=20, R=0 after 21 busy cycles. The next operation starts on the cycle Ready rises.
- Start 250/2, assert reset 5 cycles later: next cycle shows Ready=1, Q=0, R=0, DivZero=0. A subsequent 9/9 gives Q=1, R=0 after 2 busy cycles.

Source files
------------

// File: rtl/divide_pkg.sv
// Shared arithmetic-unit definitions: controller state encodings and default width.
// The multiplier uses the same encodings so one sequencer can drive both units.
package divide_pkg;

  localparam int ARITH_WIDTH = 8;

  typedef enum logic {
    S_Idle = 1'b0,
    S_Div  = 1'b1
  } arith_state_e;

endpackage

// File: rtl/divide_ctrl.sv
// Two-state controller for the repeated-subtraction divider.
// It decodes Ready, Load and Sub from the state register.
module divide_ctrl
  import divide_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic ge,
  input  logic dz,
  output logic ready,
  output logic load,
  output logic sub
);

  arith_state_e state;

  always_comb begin
    ready = (state == S_Idle);
    load  = ready & start;
    sub   = (state == S_Div) & ge;
  end

  // A zero divisor finishes in the load cycle, so the FSM stays idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_Idle;
    end else begin
      case (state)
        S_Idle:  if (load && !dz) state <= S_Div;
        S_Div:   if (!sub)        state <= S_Idle;
        default: state <= S_Idle;
      endcase
    end
  end

endmodule

// File: rtl/divide_dp.sv
// Divider datapath: divisor, remainder, quotient and divide-by-zero registers,
// plus the >= comparator that guards the subtractor against underflow.
module divide_dp
  import divide_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             sub,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             ge,
  output logic             dz
);

  logic [WIDTH-1:0] d_reg;

  assign dz = (divisor == '0);
  assign ge = (remainder >= d_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      d_reg     <= '0;
      remainder <= '0;
      quotient  <= '0;
      div_zero  <= 1'b0;
    end else if (load) begin
      remainder <= dividend;
      if (dz) begin
        // Saturated quotient marks the undefined result; D is left untouched.
        quotient <= '1;
        div_zero <= 1'b1;
      end else begin
        d_reg    <= divisor;
        quotient <= '0;
        div_zero <= 1'b0;
      end
    end else if (sub) begin
      remainder <= remainder - d_reg;
      quotient  <= quotient + WIDTH'(1);
    end
  end

endmodule

// File: rtl/divide.sv
// Sequential unsigned divider by repeated subtraction (start/Ready handshake).
// Busy time is quotient+1 cycles; a zero divisor completes without going busy.
module divide
  import divide_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Ready,
  output logic             DivZero
);

  logic load;
  logic sub;
  logic ge;
  logic dz;

  divide_ctrl u_ctrl (
    .clock (clock),
    .reset (reset),
    .start (start),
    .ge    (ge),
    .dz    (dz),
    .ready (Ready),
    .load  (load),
    .sub   (sub)
  );

  divide_dp #(.WIDTH(WIDTH)) u_dp (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .sub       (sub),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (Quotient),
    .remainder (Remainder),
    .div_zero  (DivZero),
    .ge        (ge),
    .dz        (dz)
  );

endmodule

// File: tb/tb_divide.sv
// Directed-vector bench for the repeated-subtraction divider.
module tb_divide;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Ready;
  logic       DivZero;

  int n_vec;
  int n_err;

  divide #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Ready     (Ready),
    .DivZero   (DivZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called at a negedge just after an accept edge; counts negedges with Ready low.
  task automatic wait_idle(input string name, output int busy);
    busy = 0;
    while (Ready !== 1'b1 && busy < 400) begin
      busy++;
      @(negedge clock);
    end
    if (busy >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: Ready still %b after %0d cycles, need 1", name, Ready, busy);
    end
  endtask

  // Pulse start for one cycle at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input int exp_busy, input logic [7:0] exp_q, input logic [7:0] exp_r);
    int busy;
    issue(a, b);
    wait_idle(name, busy);
    n_vec++;
    if (busy !== exp_busy) begin
      n_err++;
      $display("FAIL %s busy: got %0d need %0d", name, busy, exp_busy);
    end
    n_vec++;
    if (Quotient !== exp_q || Remainder !== exp_r || DivZero !== 1'b0) begin
      n_err++;
      $display("FAIL %s result: got Q=%0d R=%0d DZ=%b need Q=%0d R=%0d DZ=0",
               name, Quotient, Remainder, DivZero, exp_q, exp_r);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clock);
    n_vec++;
    if (Ready !== 1'b1 || Quotient !== 8'd0 || Remainder !== 8'd0 || DivZero !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got Ready=%b Q=%0d R=%0d DZ=%b need 1/0/0/0",
               Ready, Quotient, Remainder, DivZero);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic;
    run_op("100/7", 8'd100, 8'd7, 15, 8'd14, 8'd2);
  endtask

  task automatic test_boundaries;
    run_op("255/1", 8'd255, 8'd1, 256, 8'd255, 8'd0);
    run_op("5/9",   8'd5,   8'd9, 1,   8'd0,   8'd5);
    run_op("0/3",   8'd0,   8'd3, 1,   8'd0,   8'd0);
    run_op("77/77", 8'd77,  8'd77, 2,  8'd1,   8'd0);
  endtask

  task automatic test_div_zero;
    issue(8'd42, 8'd0);
    n_vec++;
    if (Ready !== 1'b1 || Quotient !== 8'hFF || Remainder !== 8'd42 || DivZero !== 1'b1) begin
      n_err++;
      $display("FAIL 42/0: got Ready=%b Q=%h R=%0d DZ=%b need 1/ff/42/1",
               Ready, Quotient, Remainder, DivZero);
    end
    // Results must hold while idle.
    repeat (3) @(negedge clock);
    n_vec++;
    if (Quotient !== 8'hFF || Remainder !== 8'd42 || DivZero !== 1'b1) begin
      n_err++;
      $display("FAIL 42/0 hold: got Q=%h R=%0d DZ=%b need ff/42/1", Quotient, Remainder, DivZero);
    end
    run_op("10/3", 8'd10, 8'd3, 4, 8'd3, 8'd1);
  endtask

  task automatic test_back_to_back;
    int busy;
    dividend = 8'd200;
    divisor  = 8'd10;
    start    = 1'b1;
    @(negedge clock);
    // Operand changes mid-op must not be re-sampled.
    dividend = 8'd17;
    divisor  = 8'd1;
    wait_idle("200/10 held", busy);
    n_vec++;
    if (busy !== 21 || Quotient !== 8'd20 || Remainder !== 8'd0) begin
      n_err++;
      $display("FAIL 200/10 held: got busy=%0d Q=%0d R=%0d need 21/20/0", busy, Quotient, Remainder);
    end
    dividend = 8'd7;
    divisor  = 8'd2;
    @(negedge clock);
    start = 1'b0;
    n_vec++;
    if (Ready !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back accept: got Ready=%b need 0", Ready);
    end
    wait_idle("7/2 b2b", busy);
    n_vec++;
    if (busy !== 4 || Quotient !== 8'd3 || Remainder !== 8'd1) begin
      n_err++;
      $display("FAIL 7/2 b2b: got busy=%0d Q=%0d R=%0d need 4/3/1", busy, Quotient, Remainder);
    end
  endtask

  task automatic test_reset_mid_op;
    issue(8'd250, 8'd2);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_vec++;
    if (Ready !== 1'b1 || Quotient !== 8'd0 || Remainder !== 8'd0 || DivZero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_op: got Ready=%b Q=%0d R=%0d DZ=%b need 1/0/0/0",
               Ready, Quotient, Remainder, DivZero);
    end
    run_op("9/9", 8'd9, 8'd9, 2, 8'd1, 8'd0);
  endtask

  task automatic test_reset_with_start;
    reset = 1'b1;
    issue(8'd99, 8'd0);
    reset = 1'b0;
    n_vec++;
    if (Ready !== 1'b1 || Quotient !== 8'd0 || Remainder !== 8'd0 || DivZero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_with_start: got Ready=%b Q=%0d R=%0d DZ=%b need 1/0/0/0",
               Ready, Quotient, Remainder, DivZero);
    end
    @(negedge clock);
    n_vec++;
    if (Ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_with_start idle: got Ready=%b need 1", Ready);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_reset_with_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
